split_palabras: RTL
===================

# split_palabras

Transmit-side word serializer: accepts one 64-bit word and emits it as 8 bytes, least-significant byte first. Byte k is data_in[8k+7:8k]. A word assembled on the receive path from bytes b0..b7 (first byte in bits 7:0) is reproduced as the same byte sequence b0..b7. Sits between the core's result register and the byte-wide UART transmitter. Uses a valid/ready handshake on both sides, with an optional idle gap between bytes.

## Interface
Parameters:
- PALABRAS, 8: bytes per word; word width is PALABRAS*8.
- BITS, 3: byte-index width, clog2(PALABRAS).
- GAP_CYCLES, 0: idle cycles inserted between consecutive bytes of one word (0..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  PALABRAS*8  word to send; sampled only on word handshake.
- word_valid  in  1  producer offers data_in.
- word_ready  out  1  registered; serializer can accept a word.
- byte_out  out  8  current byte.
- byte_valid  out  1  registered; byte_out is valid.
- byte_ready  in  1  transmitter accepts byte_out this cycle.
- busy  out  1  registered; high from word accept until the last byte is accepted.
- done  out  1  registered; one-cycle pulse after the last byte is accepted.

## Operation
- States: IDLE, SEND, GAP.
- Reset (rst high at an edge):
  - state goes to IDLE.
  - word_ready, byte_valid, busy and done go to 0.
  - byte_out, shift register, index and gap counter go to 0.
  - word_ready rises on the first edge with rst low.
- IDLE:
  - word_ready=1.
  - word_valid&&word_ready at an edge loads the shift register with data_in and sets idx=0, busy=1, word_ready=0, byte_valid=1, byte_out=data_in[7:0]. State goes to SEND.
- SEND:
  - byte_valid=1.
  - byte_out is held stable while byte_ready=0.
  - byte_valid&&byte_ready at an edge with idx<PALABRAS-1: shift register shifts right by 8 and idx increments.
    - If GAP_CYCLES=0: the next byte is presented immediately and state stays SEND.
    - Otherwise: byte_valid=0, the gap counter loads GAP_CYCLES-1 and state goes to GAP.
  - Handshake with idx=PALABRAS-1: byte_valid=0, busy=0, done=1, word_ready=1, state goes to IDLE.
- GAP:
  - byte_valid=0.
  - Counter decrements each cycle. At 0: byte_valid=1 with the next byte, state goes to SEND.
- word_valid is ignored whenever word_ready=0; data_in changes outside the handshake have no effect.
- done is cleared on the cycle after it pulses.
- byte_ready while byte_valid=0 is ignored.
- rst asserted mid-word aborts the word: remaining bytes are dropped, no done pulse, and the same-edge handshake is discarded.
- Index wrap-around never occurs; idx resets to 0 only on word load.

## Timing
- Word accepted at edge T: byte0 is valid from T+1. Latency is one cycle.
- With byte_ready held 1 and GAP_CYCLES=0:
  - one byte per cycle, bytes 0..7 in cycles T+1..T+8.
  - done=1 and word_ready=1 in cycle T+9.
  - The next word can be accepted at the end of T+9, giving a 9-cycle word period.
- With GAP_CYCLES=G and byte_ready held 1:
  - byte_valid low for exactly G cycles between bytes.
  - word period = 9+7G cycles.
- Back-pressure: each cycle byte_ready=0 with byte_valid=1 extends the word by one cycle, with no byte loss or duplication.
- No combinational path from any input to any output.

## Structure
- Shared package tx_pkg holds:
  - the state enum (IDLE, SEND, GAP), 2-bit encoding;
  - localparams PALABRAS_DEF=8 and BYTE_W=8.
  - The receive-side assembler uses the same PALABRAS default.
- One natural sub-module, byte_gap_timer:
  - loadable down-counter with a zero flag;
  - width max(1,clog2(GAP_CYCLES+1));
  - tied off when GAP_CYCLES=0.
- Shift register, index and FSM live in split_palabras.

## Test plan
- Reset, then word 64'h0807060504030201 with byte_ready=1, GAP=0:
  - bytes 01,02,…,08 on consecutive cycles;
  - done pulses once in cycle T+9;
  - busy is high for 8 cycles.
- Same word with byte_ready toggling 1,0,0,1…:
  - each byte is held stable while ready=0;
  - the sequence is unchanged, with no duplicates.
- GAP_CYCLES=3, word 64'hFFEEDDCCBBAA9988:
  - 3 low-valid cycles between each of the 8 bytes;
  - done 30 cycles after accept.
- word_valid held high during transmission with changing data_in:
  - only the first word is sent;
  - the second word is accepted only when word_ready returns, and its bytes follow.
- rst pulsed after byte 3 handshake:
  - all outputs 0 next cycle, no done;
  - a fresh word 64'h1 then sends 01,00×7 correctly.
- Loopback: serializer output feeds the receive-side 8-byte assembler; 20 random words round-trip bit-exact.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the byte-serial transmit path.
//   tx_state_t   : serializer FSM state (IDLE, SEND, GAP), 2-bit encoding
//   PALABRAS_DEF : default bytes per word, also used by the receive-side assembler
//   BYTE_W       : width of one byte lane
package tx_pkg;
  localparam int PALABRAS_DEF = 8;
  localparam int BYTE_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;
endpackage

// File: rtl/split_palabras_if.sv
// Word-in / byte-out handshake bundle for the serializer.
//   data_in, word_valid, word_ready : word side (producer -> serializer)
//   byte_out, byte_valid, byte_ready : byte side (serializer -> transmitter)
//   busy, done                       : status
// slave  : serializer view
// master : producer/transmitter view
interface split_palabras_if import tx_pkg::*; #(
  parameter int PALABRAS = PALABRAS_DEF
) ();
  logic [PALABRAS*BYTE_W-1:0] data_in;
  logic                       word_valid;
  logic                       word_ready;
  logic [BYTE_W-1:0]          byte_out;
  logic                       byte_valid;
  logic                       byte_ready;
  logic                       busy;
  logic                       done;

  modport slave (
    input  data_in, word_valid, byte_ready,
    output word_ready, byte_out, byte_valid, busy, done
  );

  modport master (
    output data_in, word_valid, byte_ready,
    input  word_ready, byte_out, byte_valid, busy, done
  );
endinterface

// File: rtl/split_palabras_byte_gap_timer.sv
// Loadable down-counter timing the idle gap between bytes.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val this edge
//   load_val  : start value (gap length minus one)
//   zero      : counter has reached zero
// The counter stops at zero on its own, so it needs no separate enable.
module byte_gap_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - W'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/split_palabras.sv
// Transmit-side word serializer: takes one PALABRAS*8-bit word and emits it
// as PALABRAS bytes, least-significant byte first, with an optional idle gap
// of GAP_CYCLES cycles between consecutive bytes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : split_palabras_if.slave (word side, byte side, busy/done)
// All outputs come straight from registers; byte_out is the low byte of the
// shift register.
//
// state | meaning
// IDLE  | word_ready high, waiting for a word
// SEND  | byte_valid high, presenting byte idx
// GAP   | byte_valid low, waiting for the gap timer to expire
module split_palabras import tx_pkg::*; #(
  parameter int PALABRAS   = PALABRAS_DEF,
  parameter int BITS       = 3,
  parameter int GAP_CYCLES = 0
) (
  input logic             clk,
  input logic             rst,
  split_palabras_if.slave bus
);
  localparam int             WORD_W   = PALABRAS * BYTE_W;
  localparam int             GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int             GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [BITS-1:0] LAST   = BITS'(PALABRAS - 1);

  tx_state_t         state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BITS-1:0]   idx_q, idx_d;
  logic              word_ready_q, word_ready_d;
  logic              byte_valid_q, byte_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              gap_load, gap_zero;
  logic              hs;

  // With no gap configured the load is never raised, so the timer stays at
  // zero and acts as a constant.
  byte_gap_timer #(.W(GW)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GW'(GAP_LOAD)),
    .zero     (gap_zero)
  );

  assign hs = byte_valid_q && bus.byte_ready;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    idx_d        = idx_q;
    word_ready_d = word_ready_q;
    byte_valid_d = byte_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    gap_load     = 1'b0;
    case (state_q)
      IDLE: begin
        word_ready_d = 1'b1;
        if (bus.word_valid && word_ready_q) begin
          shreg_d      = bus.data_in;
          idx_d        = '0;
          busy_d       = 1'b1;
          word_ready_d = 1'b0;
          byte_valid_d = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (idx_q == LAST) begin
            byte_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            word_ready_d = 1'b1;
            state_d      = IDLE;
          end else begin
            shreg_d = shreg_q >> BYTE_W;
            idx_d   = idx_q + BITS'(1);
            if (GAP_CYCLES > 0) begin
              byte_valid_d = 1'b0;
              gap_load     = 1'b1;
              state_d      = GAP;
            end
          end
        end
      end
      GAP: begin
        if (gap_zero) begin
          byte_valid_d = 1'b1;
          state_d      = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      idx_q        <= '0;
      word_ready_q <= 1'b0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      word_ready_q <= word_ready_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.word_ready = word_ready_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_out   = shreg_q[BYTE_W-1:0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule
